// File: rtl/hack_bus_pkg.sv
// Shared definitions for the HACK data-memory bus blocks: widths, the
// ownership enum used by arbiters, and small ownership helpers.
package hack_bus_pkg;

    localparam int HACK_DATA_W = 16;
    localparam int HACK_ADDR_W = 15;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // The requester that is not o; OWN_NONE maps to itself.
    function automatic owner_t other_owner(input owner_t o);
        case (o)
            OWN_A:   return OWN_B;
            OWN_B:   return OWN_A;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Two-requester data-memory bus: per-requester request/grant/read-valid
// channels plus the steered RAM port. Requesters drive master, the arbiter is slave.
interface hack_mem_arbiter_if;
    import hack_bus_pkg::*;

    logic                   a_req;
    logic [HACK_ADDR_W-1:0] a_addr;
    logic [HACK_DATA_W-1:0] a_wdata;
    logic                   a_we;
    logic                   a_gnt;
    logic                   a_rvalid;

    logic                   b_req;
    logic [HACK_ADDR_W-1:0] b_addr;
    logic [HACK_DATA_W-1:0] b_wdata;
    logic                   b_we;
    logic                   b_gnt;
    logic                   b_rvalid;

    logic                   mem_sel;
    logic                   mem_en;
    logic                   mem_we;
    logic [HACK_ADDR_W-1:0] mem_addr;
    logic [HACK_DATA_W-1:0] mem_wdata;

    modport master (
        output a_req, a_addr, a_wdata, a_we,
        output b_req, b_addr, b_wdata, b_we,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid,
        input  mem_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  a_req, a_addr, a_wdata, a_we,
        input  b_req, b_addr, b_wdata, b_we,
        output a_gnt, a_rvalid, b_gnt, b_rvalid,
        output mem_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/Mux.sv
// HACK 1-bit two-way multiplexer: out = sel ? b : a.
module Mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/Mux16.sv
// HACK 16-bit two-way multiplexer: out = sel ? b : a.
module Mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/hack_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever requester did not own the port most recently.
module hack_rr_pick2 import hack_bus_pkg::*; (
    input  logic   req_a,
    input  logic   req_b,
    input  owner_t last_owner,
    output owner_t winner
);

    // Winner selection from the current request pair.
    always_comb begin
        winner = OWN_NONE;
        case ({req_a, req_b})
            2'b10:   winner = OWN_A;
            2'b01:   winner = OWN_B;
            2'b11:   winner = (last_owner == OWN_A) ? OWN_B : OWN_A;
            default: winner = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Round-robin arbiter for the single HACK data-memory port: sequences ownership
// between the CPU (A) and the I/O/DMA engine (B) with a bounded burst per owner.
module hack_mem_arbiter import hack_bus_pkg::*; #(
    parameter int DATA_W    = HACK_DATA_W,
    parameter int ADDR_W    = HACK_ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hack_mem_arbiter_if.slave bus
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    owner_t             state_r;
    owner_t             state_nxt_s;
    owner_t             last_owner_r;
    owner_t             pick_s;
    logic [3:0]         beat_cnt_r;
    logic               a_gnt_r;
    logic               b_gnt_r;
    logic               mem_sel_r;
    logic               a_rvalid_r;
    logic               b_rvalid_r;
    logic               owner_req_s;
    logic               other_req_s;
    logic               beat_s;
    logic               we_sel_s;
    logic [15:0]        addr16_s;
    logic [DATA_W-1:0]  wdata_s;
    logic               addr_msb_unused_s;
    logic [ADDR_W-1:0]  addr_s;

    hack_rr_pick2 u_pick (
        .req_a      (bus.a_req),
        .req_b      (bus.b_req),
        .last_owner (last_owner_r),
        .winner     (pick_s)
    );

    // The steering muxes follow mem_sel, which holds its last value while idle.
    Mux16 u_wdata_mux (
        .a   (bus.a_wdata),
        .b   (bus.b_wdata),
        .sel (mem_sel_r),
        .out (wdata_s)
    );

    Mux16 u_addr_mux (
        .a   ({{(16 - ADDR_W){1'b0}}, bus.a_addr}),
        .b   ({{(16 - ADDR_W){1'b0}}, bus.b_addr}),
        .sel (mem_sel_r),
        .out (addr16_s)
    );

    Mux u_we_mux (
        .a   (bus.a_we),
        .b   (bus.b_we),
        .sel (mem_sel_r),
        .out (we_sel_s)
    );

    assign {addr_msb_unused_s, addr_s} = addr16_s;

    // A beat is the owner's request while it holds the grant.
    assign beat_s = (a_gnt_r & bus.a_req) | (b_gnt_r & bus.b_req);

    // Owner/other request view of the current state.
    always_comb begin
        owner_req_s = 1'b0;
        other_req_s = 1'b0;
        case (state_r)
            OWN_A: begin
                owner_req_s = bus.a_req;
                other_req_s = bus.b_req;
            end
            OWN_B: begin
                owner_req_s = bus.b_req;
                other_req_s = bus.a_req;
            end
            default: begin
                owner_req_s = 1'b0;
                other_req_s = 1'b0;
            end
        endcase
    end

    // Next-state decision; the last beat of a burst and the handover share a cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            OWN_NONE: state_nxt_s = pick_s;
            OWN_A, OWN_B: begin
                if (!owner_req_s) begin
                    state_nxt_s = other_req_s ? other_owner(state_r) : OWN_NONE;
                end else if (other_req_s && (beat_cnt_r == BURST_LAST)) begin
                    state_nxt_s = other_owner(state_r);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = OWN_NONE;
        endcase
    end

    // Ownership FSM with registered grants, select, burst counter and read-valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= OWN_NONE;
            last_owner_r <= OWN_B;
            beat_cnt_r   <= 4'd0;
            a_gnt_r      <= 1'b0;
            b_gnt_r      <= 1'b0;
            mem_sel_r    <= 1'b0;
            a_rvalid_r   <= 1'b0;
            b_rvalid_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_gnt_r <= (state_nxt_s == OWN_A);
            b_gnt_r <= (state_nxt_s == OWN_B);

            if (state_nxt_s == OWN_A) begin
                mem_sel_r <= 1'b0;
            end else if (state_nxt_s == OWN_B) begin
                mem_sel_r <= 1'b1;
            end else begin
                mem_sel_r <= mem_sel_r;
            end

            if (state_nxt_s != OWN_NONE) begin
                last_owner_r <= state_nxt_s;
            end else begin
                last_owner_r <= last_owner_r;
            end

            // Saturating at the burst limit keeps a sole requester's count meaningful
            // for the moment the other side finally asks.
            if ((state_nxt_s != state_r) || (state_nxt_s == OWN_NONE)) begin
                beat_cnt_r <= 4'd0;
            end else if (beat_s && (beat_cnt_r != BURST_LAST)) begin
                beat_cnt_r <= beat_cnt_r + 4'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end

            a_rvalid_r <= a_gnt_r & bus.a_req & ~bus.a_we;
            b_rvalid_r <= b_gnt_r & bus.b_req & ~bus.b_we;
        end
    end

    assign bus.a_gnt     = a_gnt_r;
    assign bus.b_gnt     = b_gnt_r;
    assign bus.a_rvalid  = a_rvalid_r;
    assign bus.b_rvalid  = b_rvalid_r;
    assign bus.mem_sel   = mem_sel_r;
    assign bus.mem_en    = beat_s;
    assign bus.mem_we    = we_sel_s & beat_s;
    assign bus.mem_addr  = addr_s;
    assign bus.mem_wdata = wdata_s;

endmodule
